// File: rtl/cs_pkg.sv
// cs_pkg
// Shared constants and types for the smoothing-core feeder.
// - N_WIN_DEF : default window length of the attached smoothing core
// - SAMP_W    : sample width presented to the core
// - RES_W     : result width returned by the core
// - state_t   : feeder sequencer states
package cs_pkg;

  localparam int N_WIN_DEF = 9;
  localparam int SAMP_W    = 8;
  localparam int RES_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cs_feeder_if.sv
// cs_feeder_if
// Bundles the sample-RAM read port, the smoothing-core port and the
// result-RAM write port that the feeder drives.
// - src_rd/src_addr/src_data : sample RAM read (data sampled with the strobe)
// - core_rst/x/y             : window clear, sample out, result in
// - res_wr/res_addr/res_data : result RAM write
// Modports: master = feeder side, slave = memories/core side.
interface cs_feeder_if #(
  parameter int AW = 6
);

  logic                     src_rd;
  logic [AW-1:0]            src_addr;
  logic [cs_pkg::SAMP_W-1:0] src_data;
  logic                     core_rst;
  logic [cs_pkg::SAMP_W-1:0] x;
  logic [cs_pkg::RES_W-1:0]  y;
  logic                     res_wr;
  logic [AW-1:0]            res_addr;
  logic [cs_pkg::RES_W-1:0]  res_data;

  modport master (
    output src_rd, src_addr, core_rst, x, res_wr, res_addr, res_data,
    input  src_data, y
  );

  modport slave (
    input  src_rd, src_addr, core_rst, x, res_wr, res_addr, res_data,
    output src_data, y
  );

endinterface

// File: rtl/cs_tag_delay.sv
// cs_tag_delay
// Shift register carrying a {valid, index} tag alongside each sample so the
// tag lines up with the core's result after LAT cycles.
// - clk/reset : clock and synchronous clear (drops all pending tags)
// - i_valid/i_idx : tag entering with the sample on x
// - o_valid/o_idx : tag aligned with the core output y
module cs_tag_delay #(
  parameter int LAT = 1,
  parameter int AW  = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [AW-1:0] i_idx,
  output logic          o_valid,
  output logic [AW-1:0] o_idx
);

  generate
    if (LAT == 0) begin : g_bypass
      assign o_valid = i_valid;
      assign o_idx   = i_idx;
    end else begin : g_shift
      logic          r_valid [LAT];
      logic [AW-1:0] r_idx   [LAT];

      // Tag pipeline: stage 0 takes the new tag, later stages shift along;
      // a clear empties every stage so no stale write can surface.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < LAT; k++) begin
            r_valid[k] <= 1'b0;
            r_idx[k]   <= '0;
          end
        end else begin
          r_valid[0] <= i_valid;
          r_idx[0]   <= i_idx;
          for (int k = 1; k < LAT; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_idx[k]   <= r_idx[k-1];
          end
        end
      end

      assign o_valid = r_valid[LAT-1];
      assign o_idx   = r_idx[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/cs_feeder.sv
// cs_feeder
// Streams DEPTH samples from the sample RAM into a sliding-window smoothing
// core and stores every full-window result into the result RAM.
// - clk     : rising-edge clock
// - reset   : synchronous active-high reset
// - i_start : run request, honoured only while idle
// - o_busy  : run in progress (reading or waiting for the last result)
// - o_done  : one-cycle pulse after the last result write
// - bus     : sample RAM read, core and result RAM write signals
module cs_feeder
  import cs_pkg::*;
#(
  parameter int N_WIN    = N_WIN_DEF,
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int CORE_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  cs_feeder_if.master bus
);

  generate
    if (DEPTH < N_WIN) begin : g_badDepth
      $error("cs_feeder: DEPTH must be at least N_WIN");
    end
    if ((2 ** AW) < DEPTH) begin : g_badAw
      $error("cs_feeder: AW too narrow for DEPTH");
    end
  endgenerate

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(N_WIN - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - N_WIN);

  state_t              r_state;
  state_t              w_stateNext;
  logic [AW-1:0]       r_readCnt;
  logic                r_coreRst;
  logic [SAMP_W-1:0]   r_x;
  logic                r_tagValid;
  logic [AW-1:0]       r_tagIdx;
  logic                w_dlyValid;
  logic [AW-1:0]       w_dlyIdx;
  logic                w_resHit;
  logic                r_resWr;
  logic [AW-1:0]       r_resAddr;
  logic [RES_W-1:0]    r_resData;
  logic                w_lastRead;
  logic                w_lastWrite;

  assign w_lastRead  = (r_readCnt == LAST_IDX);
  assign w_lastWrite = r_resWr && (r_resAddr == LAST_ADDR);
  // Only indices whose window is fully populated produce a result.
  assign w_resHit    = w_dlyValid && (w_dlyIdx >= FIRST_IDX);

  // Next-state logic: RUN ends after the last address is issued, DRAIN ends
  // once the result for the final sample has been written.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (i_start)     w_stateNext = ST_RUN;
      ST_RUN:   if (w_lastRead)  w_stateNext = ST_DRAIN;
      ST_DRAIN: if (w_lastWrite) w_stateNext = ST_DONE;
      ST_DONE:                   w_stateNext = ST_IDLE;
      default:                   w_stateNext = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  // Read counter advances once per read; it rests at zero outside RUN so a
  // new run always starts from address 0.
  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_RUN)) begin
      r_readCnt <= '0;
    end else if (!w_lastRead) begin
      r_readCnt <= r_readCnt + AW'(1);
    end
  end

  // Datapath: window clear on run start, sample capture with its tag, and
  // the registered result write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coreRst  <= 1'b0;
      r_x        <= '0;
      r_tagValid <= 1'b0;
      r_tagIdx   <= '0;
      r_resWr    <= 1'b0;
      r_resAddr  <= '0;
      r_resData  <= '0;
    end else begin
      r_coreRst  <= (r_state == ST_IDLE) && i_start;
      r_tagValid <= bus.src_rd;
      if (bus.src_rd) begin
        r_x      <= bus.src_data;
        r_tagIdx <= r_readCnt;
      end
      r_resWr <= w_resHit;
      if (w_resHit) begin
        r_resAddr <= w_dlyIdx - FIRST_IDX;
        r_resData <= bus.y;
      end
    end
  end

  cs_tag_delay #(
    .LAT (CORE_LAT),
    .AW  (AW)
  ) u_tagDelay (
    .clk     (clk),
    .reset   (reset),
    .i_valid (r_tagValid),
    .i_idx   (r_tagIdx),
    .o_valid (w_dlyValid),
    .o_idx   (w_dlyIdx)
  );

  assign bus.src_rd   = (r_state == ST_RUN);
  assign bus.src_addr = r_readCnt;
  assign bus.core_rst = r_coreRst;
  assign bus.x        = r_x;
  assign bus.res_wr   = r_resWr;
  assign bus.res_addr = r_resAddr;
  assign bus.res_data = r_resData;
  assign o_busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_cs_feeder.sv
// tb_cs_feeder
// Directed bench for cs_feeder: a 16-sample instance and a 9-sample instance
// (window 9, core latency 1), each with a sample RAM holding RAM[i] = i and a
// core stub returning {2'b0, x} one cycle later.
module tb_cs_feeder;

  localparam int AW = 4;
  localparam int NW = 9;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic startA = 1'b0;
  logic startB = 1'b0;
  logic busyA, doneA, busyB, doneB;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  cs_feeder_if #(.AW(AW)) busA ();
  cs_feeder_if #(.AW(AW)) busB ();

  cs_feeder #(.N_WIN(NW), .DEPTH(16), .AW(AW), .CORE_LAT(1)) dutA (
    .clk     (clk),
    .reset   (reset),
    .i_start (startA),
    .o_busy  (busyA),
    .o_done  (doneA),
    .bus     (busA)
  );

  cs_feeder #(.N_WIN(NW), .DEPTH(9), .AW(AW), .CORE_LAT(1)) dutB (
    .clk     (clk),
    .reset   (reset),
    .i_start (startB),
    .o_busy  (busyB),
    .o_done  (doneB),
    .bus     (busB)
  );

  // Sample RAMs hold their own address; the core stubs echo x one cycle late.
  assign busA.src_data = {4'b0000, busA.src_addr};
  assign busB.src_data = {4'b0000, busB.src_addr};

  always @(posedge clk) begin
    busA.y <= {2'b00, busA.x};
    busB.y <= {2'b00, busB.x};
  end

  // Counts one comparison and reports it when the observed value is off.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Runs 26 cycles from cycle 0, pulsing start at s0/s1/s2 and reset at rstC
  // (-1 = never), checking every output each cycle against the timeline of
  // a run of the given depth, then the totals of writes and done pulses.
  task automatic applyStimulus(input int sel, input int depth, input int s0,
                               input int s1, input int s2, input int rstC,
                               input int expWrites, input int expDones);
    int writes = 0;
    int dones  = 0;
    string pfx;
    bit zero, eRd, eWr;
    logic oRd, oCoreRst, oBusy, oDone, oWr;
    logic [AW-1:0] oAddr, oResAddr;
    logic [7:0] oX;
    logic [9:0] oResData;
    for (int c = 0; c < 26; c++) begin
      startA = (sel == 0) && (c == s0 || c == s1 || c == s2);
      startB = (sel == 1) && (c == s0 || c == s1 || c == s2);
      reset  = (c == rstC);
      @(negedge clk);
      if (sel == 0) begin
        oRd = busA.src_rd; oAddr = busA.src_addr; oCoreRst = busA.core_rst;
        oX = busA.x; oWr = busA.res_wr; oResAddr = busA.res_addr;
        oResData = busA.res_data; oBusy = busyA; oDone = doneA;
      end else begin
        oRd = busB.src_rd; oAddr = busB.src_addr; oCoreRst = busB.core_rst;
        oX = busB.x; oWr = busB.res_wr; oResAddr = busB.res_addr;
        oResData = busB.res_data; oBusy = busyB; oDone = doneB;
      end
      pfx  = $sformatf("%s c%0d", (sel == 0) ? "A" : "B", c);
      zero = (s0 < 0) || (rstC >= 0 && c > rstC);
      eRd  = !zero && c >= 1 && c <= depth;
      eWr  = !zero && c >= NW + 3 && c <= depth + 3;
      checkOutput({pfx, " src_rd"},   32'(oRd),      32'(eRd));
      checkOutput({pfx, " core_rst"}, 32'(oCoreRst), 32'(!zero && c == 1));
      checkOutput({pfx, " busy"},     32'(oBusy),    32'(!zero && c >= 1 && c <= depth + 3));
      checkOutput({pfx, " done"},     32'(oDone),    32'(!zero && c == depth + 4));
      checkOutput({pfx, " res_wr"},   32'(oWr),      32'(eWr));
      if (zero) begin
        checkOutput({pfx, " src_addr"}, 32'(oAddr),    0);
        checkOutput({pfx, " x"},        32'(oX),       0);
        checkOutput({pfx, " res_addr"}, 32'(oResAddr), 0);
        checkOutput({pfx, " res_data"}, 32'(oResData), 0);
      end else begin
        if (eRd) checkOutput({pfx, " src_addr"}, 32'(oAddr), 32'(c - 1));
        if (c >= 2 && c <= depth + 1) checkOutput({pfx, " x"}, 32'(oX), 32'(c - 2));
        if (eWr) begin
          checkOutput({pfx, " res_addr"}, 32'(oResAddr), 32'(c - (NW + 3)));
          checkOutput({pfx, " res_data"}, 32'(oResData), 32'(c - 4));
        end
      end
      if (oWr === 1'b1) writes++;
      if (oDone === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    startA = 1'b0;
    startB = 1'b0;
    reset  = 1'b0;
    checkOutput($sformatf("%s write count", (sel == 0) ? "A" : "B"), 32'(writes), 32'(expWrites));
    checkOutput($sformatf("%s done count", (sel == 0) ? "A" : "B"), 32'(dones), 32'(expDones));
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    // idle after reset: everything stays at zero
    applyStimulus(0, 16, -1, -1, -1, -1, 0, 0);
    // clean run: 8 writes (addr j <- j+8), done at cycle 20
    applyStimulus(0, 16, 0, -1, -1, -1, 8, 1);
    // start repeated in RUN and DRAIN is ignored
    applyStimulus(0, 16, 0, 3, 18, -1, 8, 1);
    // reset in cycle 10 aborts the run before any write
    applyStimulus(0, 16, 0, -1, -1, 10, 0, 0);
    // fresh run after the abort gives identical results
    applyStimulus(0, 16, 0, -1, -1, -1, 8, 1);
    // start together with reset: reset wins, no reads
    applyStimulus(0, 16, 0, -1, -1, 0, 0, 0);
    // DEPTH equal to the window: one write, addr 0 <- 8
    applyStimulus(1, 9, 0, -1, -1, -1, 1, 1);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
